sn_cfg_sequencer: RTL
=====================

// Module: sn_cfg_sequencer
// PURPOSE
//  Command-driven configuration and run sequencer for sn_network_dut. It accepts a valid/ready command stream from
//  the software/IO side and turns it into network-side signals: neuron memory writes (io_we/io_waddr/io_wdata),
//  period-count loads, held input currents and start pulses. It locks out configuration while a run is in
//  progress and detects illegal commands and hung runs.
// PARAMETERS
//  P_NUM_NEURONS      100  total neurons incl. inputs/outputs (index 0 reserved)
//  P_NUM_INPUTS       45   input neurons, indices 1..P_NUM_INPUTS
//  P_TABLE_NUM_ROWS   20   weight table rows per neuron; regs per neuron = 2*ROWS+2
//  P_NEUR_CURRENT_BW  12   data/current width
//  P_MAX_NUM_PERIODS  100  max legal period count
//  P_TIMEOUT_CYC      4096 RUN watchdog limit, cycles
//  L_ADDR_BW = $clog2(P_NUM_NEURONS+1)+$clog2(2*P_TABLE_NUM_ROWS+2); L_PER_BW = $clog2(P_MAX_NUM_PERIODS+1)
// PORTS
//  clk                in   1                     clock
//  rst                in   1                     synchronous, active-high reset
//  cmd_vld            in   1                     command valid
//  cmd_rdy            out  1                     command ready; accept = cmd_vld & cmd_rdy
//  cmd_op             in   2                     0 WR_MEM, 1 WR_INPUT, 2 SET_PER, 3 START
//  cmd_addr           in   L_ADDR_BW             {neuron idx (MSB), reg idx (LSB)}
//  cmd_data           in   P_NEUR_CURRENT_BW     write data / input current / period count (LSBs)
//  io_we              out  1                     neuron mem write strobe
//  io_waddr           out  L_ADDR_BW             neuron mem address
//  io_wdata           out  P_NEUR_CURRENT_BW     neuron mem data
//  io_nc_num_per_wen  out  1                     period-count load strobe
//  io_nc_num_per_d    out  L_PER_BW              period count
//  io_net_inputs      out  [P_NUM_INPUTS:1][BW]  held input currents
//  io_nc_start        out  1                     run start pulse
//  nc_io_done         in   1                     run complete from net ctrlr
//  busy               out  1                     run in progress
//  done_pulse         out  1                     one-cycle run-complete pulse
//  run_cnt            out  16                    completed runs, wraps 0xFFFF->0
//  err_illegal        out  1                     sticky illegal-command flag
//  err_timeout        out  1                     sticky watchdog flag
//  err_clr            in   1                     clears both error flags
// BEHAVIOUR
//  - Reset: all outputs 0, io_net_inputs all 0, state IDLE, per_cfgd=0, watchdog 0. cmd_rdy=0 during the reset cycle.
//  - All outputs are registered. Each strobe asserts for exactly one cycle, in the cycle after the command is accepted.
//  - FSM:
//    IDLE: cmd_rdy=1. START with per_cfgd=1 goes to LAUNCH. Other ops execute and stay in IDLE.
//    LAUNCH: io_nc_start=1, busy=1, cmd_rdy=0, watchdog=0. Next state RUN. nc_io_done is ignored in LAUNCH.
//    RUN: busy=1, cmd_rdy=0, watchdog increments every cycle.
//      nc_io_done=1 goes to COMPLETE.
//      Otherwise watchdog==P_TIMEOUT_CYC-1 sets err_timeout and goes to IDLE.
//      If both happen in the same cycle, done wins.
//    COMPLETE: done_pulse=1, run_cnt+1, busy=0. Next state IDLE.
//  - WR_MEM: neuron idx must be in P_NUM_INPUTS+1..P_NUM_NEURONS and reg idx < 2*ROWS+2. Legal: drive io_we/io_waddr/io_wdata.
//  - WR_INPUT: neuron idx must be in 1..P_NUM_INPUTS; reg idx is ignored. Legal: io_net_inputs[idx]<=cmd_data.
//    Inputs hold their values across runs.
//  - SET_PER: cmd_data[L_PER_BW-1:0] must be in 1..P_MAX_NUM_PERIODS and upper data bits must be 0.
//    Legal: pulse io_nc_num_per_wen, hold io_nc_num_per_d, set per_cfgd.
//  - START with per_cfgd=0 is illegal.
//  - Illegal command: accepted (handshake completes), no side effects, err_illegal<=1.
//  - err_clr clears both flags. If an error is set in the same cycle as err_clr, the set wins.
//  - nc_io_done in IDLE/COMPLETE is ignored.
//  - rst mid-run returns to IDLE. No done_pulse is generated and per_cfgd is cleared.
// TESTING
//  1 WR_MEM addr={7'd50,6'd3} data=12'h0A5 -> next cycle io_we=1, io_waddr=13'hC83, io_wdata=12'h0A5, for one cycle.
//  2 WR_MEM neuron 10 (input), then reg 42 on neuron 60 -> io_we stays 0, err_illegal=1.
//    err_clr -> err_illegal=0.
//  3 WR_INPUT idx 45 data 12'h3FF, then idx 46 -> io_net_inputs[45]=12'h3FF; second command sets err_illegal.
//  4 SET_PER 25, START, nc_io_done raised 40 cycles later
//    -> num_per_wen pulse with d=25; start pulse; cmd_rdy=0 throughout the run; done_pulse; run_cnt=1; cmd_rdy=1.
//  5 START after reset with no SET_PER -> no io_nc_start, err_illegal=1.
//    With P_TIMEOUT_CYC=64 and done withheld -> err_timeout at RUN cycle 64, back to IDLE.
//  6 rst asserted in RUN -> next cycle all outputs 0, busy=0, run_cnt unchanged=0.
//    START without a new SET_PER is illegal.

Source files
------------

// File: rtl/sn_cfg_sequencer.sv
// Configuration and run sequencer for sn_network_dut.
// Turns a valid/ready command stream into neuron writes, period loads and start pulses.
module sn_cfg_sequencer #(
    parameter int  P_NUM_NEURONS     = 100,
    parameter int  P_NUM_INPUTS      = 45,
    parameter int  P_TABLE_NUM_ROWS  = 20,
    parameter int  P_NEUR_CURRENT_BW = 12,
    parameter int  P_MAX_NUM_PERIODS = 100,
    parameter int  P_TIMEOUT_CYC     = 4096,
    localparam int L_NEUR_BW = $clog2(P_NUM_NEURONS + 1),
    localparam int L_REGS    = 2 * P_TABLE_NUM_ROWS + 2,
    localparam int L_REG_BW  = $clog2(L_REGS),
    localparam int L_ADDR_BW = L_NEUR_BW + L_REG_BW,
    localparam int L_PER_BW  = $clog2(P_MAX_NUM_PERIODS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_vld,
    output logic                          cmd_rdy,
    input  logic [1:0]                    cmd_op,
    input  logic [L_ADDR_BW-1:0]          cmd_addr,
    input  logic [P_NEUR_CURRENT_BW-1:0]  cmd_data,
    output logic                          io_we,
    output logic [L_ADDR_BW-1:0]          io_waddr,
    output logic [P_NEUR_CURRENT_BW-1:0]  io_wdata,
    output logic                          io_nc_num_per_wen,
    output logic [L_PER_BW-1:0]           io_nc_num_per_d,
    output logic [P_NUM_INPUTS:1][P_NEUR_CURRENT_BW-1:0] io_net_inputs,
    output logic                          io_nc_start,
    input  logic                          nc_io_done,
    output logic                          busy,
    output logic                          done_pulse,
    output logic [15:0]                   run_cnt,
    output logic                          err_illegal,
    output logic                          err_timeout,
    input  logic                          err_clr
);

    localparam int L_WD_BW = $clog2(P_TIMEOUT_CYC + 1);
    localparam int L_DW    = P_NEUR_CURRENT_BW;

    localparam logic [1:0] OP_WR_MEM   = 2'd0;
    localparam logic [1:0] OP_WR_INPUT = 2'd1;
    localparam logic [1:0] OP_SET_PER  = 2'd2;
    localparam logic [1:0] OP_START    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_COMPLETE
    } state_t;

    state_t                  state_q, state_d;
    logic [L_WD_BW-1:0]      wd_q, wd_d;
    logic                    per_cfgd_q, per_cfgd_d;
    logic                    cmd_rdy_q, cmd_rdy_d;
    logic                    we_q, we_d;
    logic [L_ADDR_BW-1:0]    waddr_q, waddr_d;
    logic [L_DW-1:0]         wdata_q, wdata_d;
    logic                    per_wen_q, per_wen_d;
    logic [L_PER_BW-1:0]     per_val_q, per_val_d;
    logic [P_NUM_INPUTS:1][L_DW-1:0] inputs_q, inputs_d;
    logic                    start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [15:0]             run_cnt_q, run_cnt_d;
    logic                    err_ill_q, err_ill_d;
    logic                    err_to_q, err_to_d;

    logic                    accept;
    logic                    set_illegal;
    logic                    set_timeout;
    logic [L_NEUR_BW-1:0]    neur;
    logic [L_REG_BW-1:0]     regi;
    logic [L_PER_BW-1:0]     per_lo;
    logic [L_DW-L_PER_BW-1:0] per_hi;
    logic                    mem_ok;
    logic                    inp_ok;
    logic                    per_ok;

    assign accept = cmd_vld & cmd_rdy_q;
    assign neur   = cmd_addr[L_ADDR_BW-1 -: L_NEUR_BW];
    assign regi   = cmd_addr[L_REG_BW-1:0];
    assign per_lo = cmd_data[L_PER_BW-1:0];
    assign per_hi = cmd_data[L_DW-1:L_PER_BW];

    assign mem_ok = (neur > L_NEUR_BW'(P_NUM_INPUTS))
                  & (neur <= L_NEUR_BW'(P_NUM_NEURONS))
                  & ({1'b0, regi} < (L_REG_BW + 1)'(L_REGS));
    assign inp_ok = (neur != '0)
                  & (neur <= L_NEUR_BW'(P_NUM_INPUTS));
    assign per_ok = (per_hi == '0)
                  & (per_lo != '0)
                  & (per_lo <= L_PER_BW'(P_MAX_NUM_PERIODS));

    // Next-state, command execution and registered-output values
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        per_cfgd_d  = per_cfgd_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        per_val_d   = per_val_q;
        inputs_d    = inputs_q;
        run_cnt_d   = run_cnt_q;
        we_d        = 1'b0;
        per_wen_d   = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_WR_MEM: begin
                            if (mem_ok) begin
                                we_d    = 1'b1;
                                waddr_d = cmd_addr;
                                wdata_d = cmd_data;
                            end else begin
                                set_illegal = 1'b1;
                            end
                        end
                        OP_WR_INPUT: begin
                            if (inp_ok) begin
                                for (int i = 1; i <= P_NUM_INPUTS; i++) begin
                                    if (neur == L_NEUR_BW'(i)) begin
                                        inputs_d[i] = cmd_data;
                                    end
                                end
                            end else begin
                                set_illegal = 1'b1;
                            end
                        end
                        OP_SET_PER: begin
                            if (per_ok) begin
                                per_wen_d  = 1'b1;
                                per_val_d  = per_lo;
                                per_cfgd_d = 1'b1;
                            end else begin
                                set_illegal = 1'b1;
                            end
                        end
                        OP_START: begin
                            if (per_cfgd_q) begin
                                state_d = S_LAUNCH;
                            end else begin
                                set_illegal = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_LAUNCH: begin
                wd_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (nc_io_done) begin
                    state_d   = S_COMPLETE;
                    run_cnt_d = run_cnt_q + 16'd1;
                end else if (wd_q == L_WD_BW'(P_TIMEOUT_CYC - 1)) begin
                    set_timeout = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wd_d = wd_q + L_WD_BW'(1);
                end
            end
            S_COMPLETE: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_rdy_d = (state_d == S_IDLE);
        start_d   = (state_d == S_LAUNCH);
        busy_d    = (state_d == S_LAUNCH) | (state_d == S_RUN);
        done_d    = (state_d == S_COMPLETE);
        err_ill_d = set_illegal | (err_ill_q & ~err_clr);
        err_to_d  = set_timeout | (err_to_q & ~err_clr);
    end

    // State and registered outputs, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wd_q       <= '0;
            per_cfgd_q <= 1'b0;
            cmd_rdy_q  <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            per_wen_q  <= 1'b0;
            per_val_q  <= '0;
            inputs_q   <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            run_cnt_q  <= '0;
            err_ill_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wd_q       <= wd_d;
            per_cfgd_q <= per_cfgd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            per_wen_q  <= per_wen_d;
            per_val_q  <= per_val_d;
            inputs_q   <= inputs_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            run_cnt_q  <= run_cnt_d;
            err_ill_q  <= err_ill_d;
            err_to_q   <= err_to_d;
        end
    end

    assign cmd_rdy           = cmd_rdy_q;
    assign io_we             = we_q;
    assign io_waddr          = waddr_q;
    assign io_wdata          = wdata_q;
    assign io_nc_num_per_wen = per_wen_q;
    assign io_nc_num_per_d   = per_val_q;
    assign io_net_inputs     = inputs_q;
    assign io_nc_start       = start_q;
    assign busy              = busy_q;
    assign done_pulse        = done_q;
    assign run_cnt           = run_cnt_q;
    assign err_illegal       = err_ill_q;
    assign err_timeout       = err_to_q;

endmodule
